// File: rtl/afu_port_rst_seq.sv
// Per-port function-level reset sequencer: drains the open TX packet, holds port reset, pulses done.
// Optional drain timeout is enabled by defining AFU_PORT_RST_DRAIN_TIMEOUT_EN.
module afu_port_rst_seq #(
  parameter int NUM_PORTS       = 8,
  parameter int RST_HOLD_CYCLES = 16,
  parameter int DRAIN_TIMEOUT   = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] flr_req,
  input  logic [NUM_PORTS-1:0] tx_tvalid,
  input  logic [NUM_PORTS-1:0] tx_tready,
  input  logic [NUM_PORTS-1:0] tx_tlast,
  output logic [NUM_PORTS-1:0] tx_gate,
  output logic [NUM_PORTS-1:0] port_rst_n,
  output logic [NUM_PORTS-1:0] flr_done,
  output logic [NUM_PORTS-1:0] timeout_err
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RESET = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(RST_HOLD_CYCLES);

  if (NUM_PORTS < 1 || RST_HOLD_CYCLES < 1 || DRAIN_TIMEOUT < 1) begin : g_cfg_err
    $error("afu_port_rst_seq: all parameters must be >= 1");
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    state_e            state_r, state_nxt_s;
    logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_nxt_s;
    logic              pend_r, pend_nxt_s;
    logic              in_pkt_r, in_pkt_nxt_s, in_pkt_upd_s;
    logic              beat_s, last_beat_s, req_s, drain_to_s;
    logic              tx_gate_r, tx_gate_nxt_s;
    logic              port_rst_n_r, port_rst_n_nxt_s;
    logic              flr_done_r, flr_done_nxt_s;

    assign beat_s      = tx_tvalid[p] & tx_tready[p];
    assign last_beat_s = beat_s & tx_tlast[p];
    // A request latched during DONE is replayed on the first RUN cycle
    assign req_s       = flr_req[p] | pend_r;

    // Packet-open tracker after this cycle's beat
    always_comb begin
      in_pkt_upd_s = in_pkt_r;
      if (last_beat_s) begin
        in_pkt_upd_s = 1'b0;
      end else if (beat_s) begin
        in_pkt_upd_s = 1'b1;
      end else begin
        in_pkt_upd_s = in_pkt_r;
      end
    end

`ifdef AFU_PORT_RST_DRAIN_TIMEOUT_EN
    localparam int DRN_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_TIMEOUT - 1);
    localparam logic [DRN_W-1:0] DRN_MAX  = DRN_W'(DRAIN_TIMEOUT);
    logic [DRN_W-1:0] drain_cnt_r;
    logic             timeout_err_r;

    assign drain_to_s = (state_r == ST_DRAIN) && (drain_cnt_r >= DRN_LAST) && !last_beat_s;

    // Cycles spent in DRAIN and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        drain_cnt_r   <= '0;
        timeout_err_r <= 1'b0;
      end else begin
        if (state_r != ST_DRAIN) begin
          drain_cnt_r <= '0;
        end else if (drain_cnt_r != DRN_MAX) begin
          drain_cnt_r <= drain_cnt_r + DRN_W'(1);
        end else begin
          drain_cnt_r <= drain_cnt_r;
        end
        timeout_err_r <= timeout_err_r | drain_to_s;
      end
    end

    assign timeout_err[p] = timeout_err_r;
`else
    assign drain_to_s     = 1'b0;
    assign timeout_err[p] = 1'b0;
`endif

    // FSM state, hold counter, pending request and packet tracker
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_r    <= ST_RUN;
        hold_cnt_r <= '0;
        pend_r     <= 1'b0;
        in_pkt_r   <= 1'b0;
      end else begin
        state_r    <= state_nxt_s;
        hold_cnt_r <= hold_cnt_nxt_s;
        pend_r     <= pend_nxt_s;
        in_pkt_r   <= in_pkt_nxt_s;
      end
    end

    // Next-state, hold counter and pending-request logic
    always_comb begin
      state_nxt_s    = state_r;
      hold_cnt_nxt_s = '0;
      pend_nxt_s     = pend_r;
      case (state_r)
        ST_RUN: begin
          pend_nxt_s = 1'b0;
          if (req_s) begin
            state_nxt_s = in_pkt_upd_s ? ST_DRAIN : ST_RESET;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (last_beat_s || drain_to_s) begin
            state_nxt_s = ST_RESET;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end
        ST_RESET: begin
          if (flr_req[p]) begin
            state_nxt_s    = ST_RESET;
            hold_cnt_nxt_s = '0;
          end else if (hold_cnt_r >= HOLD_LAST) begin
            state_nxt_s    = ST_DONE;
            hold_cnt_nxt_s = '0;
          end else begin
            state_nxt_s    = ST_RESET;
            hold_cnt_nxt_s = (hold_cnt_r == HOLD_MAX) ? hold_cnt_r : hold_cnt_r + HOLD_W'(1);
          end
        end
        ST_DONE: begin
          state_nxt_s = ST_RUN;
          pend_nxt_s  = pend_r | flr_req[p];
        end
        default: begin
          state_nxt_s = ST_RUN;
          pend_nxt_s  = 1'b0;
        end
      endcase
    end

    // Output values for the coming cycle, derived from the next state
    always_comb begin
      in_pkt_nxt_s     = 1'b0;
      tx_gate_nxt_s    = 1'b0;
      port_rst_n_nxt_s = 1'b1;
      flr_done_nxt_s   = 1'b0;
      if ((state_r == ST_RESET) || (state_nxt_s == ST_RESET)) begin
        in_pkt_nxt_s = 1'b0;
      end else begin
        in_pkt_nxt_s = in_pkt_upd_s;
      end
      tx_gate_nxt_s    = (state_nxt_s == ST_RUN) | in_pkt_nxt_s;
      port_rst_n_nxt_s = (state_nxt_s != ST_RESET);
      flr_done_nxt_s   = (state_nxt_s == ST_DONE);
    end

    // Registered port outputs; AFUs stay in reset alongside the system
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tx_gate_r    <= 1'b0;
        port_rst_n_r <= 1'b0;
        flr_done_r   <= 1'b0;
      end else begin
        tx_gate_r    <= tx_gate_nxt_s;
        port_rst_n_r <= port_rst_n_nxt_s;
        flr_done_r   <= flr_done_nxt_s;
      end
    end

    assign tx_gate[p]    = tx_gate_r;
    assign port_rst_n[p] = port_rst_n_r;
    assign flr_done[p]   = flr_done_r;
  end

endmodule

// File: tb/tb_afu_port_rst_seq.sv
// Scoreboard bench for afu_port_rst_seq: directed stimulus queues expected levels and done pulses.
module tb_afu_port_rst_seq;

  localparam int S_RST  = 0;
  localparam int S_GATE = 1;
  localparam int S_DONE = 2;
  localparam int S_TERR = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] flr_req, tx_tvalid, tx_tready, tx_tlast;
  logic [7:0] tx_gate, port_rst_n, flr_done, timeout_err;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int         cyc;
    int         sel;
    logic [7:0] mask;
    logic [7:0] val;
  } lvl_t;
  typedef struct {
    int         cyc;
    logic [7:0] vec;
  } done_t;

  lvl_t  lvl_q[$];
  done_t done_q[$];

  afu_port_rst_seq #(
    .NUM_PORTS(8),
    .RST_HOLD_CYCLES(16),
    .DRAIN_TIMEOUT(100)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flr_req(flr_req),
    .tx_tvalid(tx_tvalid),
    .tx_tready(tx_tready),
    .tx_tlast(tx_tlast),
    .tx_gate(tx_gate),
    .port_rst_n(port_rst_n),
    .flr_done(flr_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [7:0] sig_of(input int sel);
    logic [7:0] v;
    case (sel)
      S_RST:   v = port_rst_n;
      S_GATE:  v = tx_gate;
      S_DONE:  v = flr_done;
      default: v = timeout_err;
    endcase
    return v;
  endfunction

  function automatic string name_of(input int sel);
    string s;
    case (sel)
      S_RST:   s = "port_rst_n";
      S_GATE:  s = "tx_gate";
      S_DONE:  s = "flr_done";
      default: s = "timeout_err";
    endcase
    return s;
  endfunction

  task automatic exp_lvl(input int c, input int sel, input logic [7:0] mask, input logic [7:0] val);
    lvl_t e;
    e.cyc = c; e.sel = sel; e.mask = mask; e.val = val;
    lvl_q.push_back(e);
  endtask

  task automatic exp_done(input int c, input logic [7:0] vec);
    done_t e;
    e.cyc = c; e.vec = vec;
    done_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares queued levels at their cycle and every done pulse against the queue head
  initial forever begin
    done_t e;
    logic [7:0] got;
    @(negedge clk);
    for (int i = lvl_q.size() - 1; i >= 0; i--) begin
      if (lvl_q[i].cyc <= cyc) begin
        checks++;
        got = sig_of(lvl_q[i].sel) & lvl_q[i].mask;
        if (lvl_q[i].cyc != cyc || got !== lvl_q[i].val) begin
          failures++;
          $display("FAIL lvl_%s cyc=%0d exp_cyc=%0d got=%h exp=%h mask=%h", name_of(lvl_q[i].sel),
                   cyc, lvl_q[i].cyc, got, lvl_q[i].val, lvl_q[i].mask);
        end
        lvl_q.delete(i);
      end
    end
    if (done_q.size() > 0 && done_q[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL done_missing cyc=%0d got=none exp=%h@%0d", cyc, done_q[0].vec, done_q[0].cyc);
      void'(done_q.pop_front());
    end
    if (flr_done !== 8'h00) begin
      checks++;
      if (done_q.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected cyc=%0d got=%h exp=00", cyc, flr_done);
      end else begin
        e = done_q.pop_front();
        if (e.cyc != cyc || e.vec !== flr_done) begin
          failures++;
          $display("FAIL done_pulse got=%h@%0d exp=%h@%0d", flr_done, cyc, e.vec, e.cyc);
        end
      end
    end
  end

  initial begin
    int n, e0, m, f, t1;
    rst_n = 1'b0; flr_req = 8'h00; tx_tvalid = 8'h00; tx_tready = 8'hFF; tx_tlast = 8'h00;

    // Reset values, then synchronous release
    exp_lvl(1, S_RST, 8'hFF, 8'h00);
    exp_lvl(1, S_GATE, 8'hFF, 8'h00);
    exp_lvl(1, S_DONE, 8'hFF, 8'h00);
    exp_lvl(1, S_TERR, 8'hFF, 8'h00);
    tick(3);
    rst_n = 1'b1;
    exp_lvl(cyc, S_RST, 8'hFF, 8'h00);
    exp_lvl(cyc + 1, S_RST, 8'hFF, 8'hFF);
    exp_lvl(cyc + 1, S_GATE, 8'hFF, 8'hFF);
    tick(5);

    // Idle FLR on port 3
    n = cyc + 1;
    exp_lvl(n - 1, S_RST, 8'hFF, 8'hFF);
    for (int k = 0; k < 16; k++) exp_lvl(n + k, S_RST, 8'hFF, 8'hF7);
    exp_lvl(n, S_GATE, 8'hFF, 8'hF7);
    exp_lvl(n + 16, S_RST, 8'hFF, 8'hFF);
    exp_lvl(n + 16, S_GATE, 8'hFF, 8'hF7);
    exp_lvl(n + 17, S_GATE, 8'hFF, 8'hFF);
    exp_done(n + 16, 8'h08);
    flr_req = 8'h08; tick(1); flr_req = 8'h00;
    tick(20);

    // Mid-packet drain on port 1; repeated request during DRAIN merges
    e0 = cyc + 1;
    m  = e0 + 4;
    exp_lvl(e0 + 2, S_GATE, 8'h02, 8'h02);
    exp_lvl(e0 + 3, S_GATE, 8'h02, 8'h02);
    exp_lvl(e0 + 3, S_RST, 8'h02, 8'h02);
    exp_lvl(m, S_GATE, 8'h02, 8'h00);
    exp_lvl(m, S_RST, 8'hFF, 8'hFD);
    exp_lvl(m + 15, S_RST, 8'hFF, 8'hFD);
    exp_lvl(m + 16, S_RST, 8'h02, 8'h02);
    exp_done(m + 16, 8'h02);
    tx_tvalid = 8'h02; tick(2);
    tx_tvalid = 8'h00; flr_req = 8'h02; tick(1);
    tx_tvalid = 8'h02; tick(1);
    flr_req = 8'h00; tx_tlast = 8'h02; tick(1);
    tx_tvalid = 8'h00; tx_tlast = 8'h00;
    tick(20);

    // Port 2: tlast handshake coincides with the request in RUN
    f = cyc + 1;
    exp_lvl(f + 1, S_RST, 8'h04, 8'h00);
    exp_lvl(f + 1, S_GATE, 8'h04, 8'h00);
    exp_lvl(f + 17, S_RST, 8'h04, 8'h04);
    exp_done(f + 17, 8'h04);
    tx_tvalid = 8'h04; tick(1);
    flr_req = 8'h04; tx_tlast = 8'h04; tick(1);
    flr_req = 8'h00; tx_tvalid = 8'h00; tx_tlast = 8'h00;
    tick(20);

    // Port 5: re-request at hold count 10 stretches the low time to 27 cycles
    n = cyc + 1;
    exp_lvl(n, S_RST, 8'h20, 8'h00);
    exp_lvl(n + 16, S_RST, 8'h20, 8'h00);
    exp_lvl(n + 26, S_RST, 8'h20, 8'h00);
    exp_lvl(n + 27, S_RST, 8'h20, 8'h20);
    exp_done(n + 27, 8'h20);
    flr_req = 8'h20; tick(1); flr_req = 8'h00;
    tick(10);
    flr_req = 8'h20; tick(1); flr_req = 8'h00;
    tick(30);

    // All ports at one edge
    n = cyc + 1;
    exp_lvl(n, S_RST, 8'hFF, 8'h00);
    exp_lvl(n, S_GATE, 8'hFF, 8'h00);
    exp_lvl(n + 15, S_RST, 8'hFF, 8'h00);
    exp_lvl(n + 16, S_RST, 8'hFF, 8'hFF);
    exp_done(n + 16, 8'hFF);
    flr_req = 8'hFF; tick(1); flr_req = 8'h00;
    tick(20);

    // Port 6: request during DONE is held pending and replayed from RUN
    n = cyc + 1;
    exp_done(n + 16, 8'h40);
    exp_lvl(n + 17, S_RST, 8'h40, 8'h40);
    exp_lvl(n + 17, S_GATE, 8'h40, 8'h40);
    exp_lvl(n + 18, S_RST, 8'h40, 8'h00);
    exp_lvl(n + 18, S_GATE, 8'h40, 8'h00);
    exp_lvl(n + 33, S_RST, 8'h40, 8'h00);
    exp_lvl(n + 34, S_RST, 8'h40, 8'h40);
    exp_done(n + 34, 8'h40);
    flr_req = 8'h40; tick(1); flr_req = 8'h00;
    tick(16);
    flr_req = 8'h40; tick(1); flr_req = 8'h00;
    tick(40);

    // Port 4: packet never closes before the request
    t1 = cyc + 2;
`ifdef AFU_PORT_RST_DRAIN_TIMEOUT_EN
    exp_lvl(t1 + 99, S_TERR, 8'h10, 8'h00);
    exp_lvl(t1 + 99, S_RST, 8'h10, 8'h10);
    exp_lvl(t1 + 100, S_RST, 8'h10, 8'h00);
    exp_lvl(t1 + 100, S_TERR, 8'hFF, 8'h10);
    exp_lvl(t1 + 100, S_GATE, 8'h10, 8'h00);
    exp_lvl(t1 + 117, S_GATE, 8'h10, 8'h10);
    exp_lvl(t1 + 130, S_TERR, 8'hFF, 8'h10);
    exp_done(t1 + 116, 8'h10);
    tx_tvalid = 8'h10; tick(1);
    tx_tvalid = 8'h00; flr_req = 8'h10; tick(1); flr_req = 8'h00;
    tick(140);
`else
    exp_lvl(t1 + 120, S_RST, 8'h10, 8'h10);
    exp_lvl(t1 + 120, S_GATE, 8'h10, 8'h10);
    exp_lvl(t1 + 120, S_TERR, 8'hFF, 8'h00);
    exp_lvl(t1 + 121, S_RST, 8'h10, 8'h00);
    exp_done(t1 + 137, 8'h10);
    tx_tvalid = 8'h10; tick(1);
    tx_tvalid = 8'h00; flr_req = 8'h10; tick(1); flr_req = 8'h00;
    tick(120);
    tx_tvalid = 8'h10; tx_tlast = 8'h10; tick(1);
    tx_tvalid = 8'h00; tx_tlast = 8'h00;
    tick(25);
`endif

    // Port 0: asynchronous system reset in the middle of RESET
    n = cyc + 1;
    exp_lvl(n + 4, S_RST, 8'hFF, 8'hFE);
    exp_lvl(n + 5, S_RST, 8'hFF, 8'h00);
    exp_lvl(n + 5, S_GATE, 8'hFF, 8'h00);
    exp_lvl(n + 5, S_TERR, 8'hFF, 8'h00);
    exp_lvl(n + 7, S_RST, 8'hFF, 8'h00);
    exp_lvl(n + 8, S_RST, 8'hFF, 8'hFF);
    exp_lvl(n + 8, S_GATE, 8'hFF, 8'hFF);
    exp_lvl(n + 8, S_DONE, 8'hFF, 8'h00);
    flr_req = 8'h01; tick(1); flr_req = 8'h00;
    tick(5);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(30);

    checks++;
    if (lvl_q.size() != 0 || done_q.size() != 0) begin
      failures++;
      $display("FAIL leftovers got=%0d/%0d exp=0/0", lvl_q.size(), done_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
